// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared state encoding and default parameters
// for the FIFO-fed UART transmitter.
package fifo_uart_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_LOAD,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;
   localparam int DEF_WIDTH_DATA   = 8;
   localparam int DEF_CLKS_PER_BIT = 16;
   localparam int DEF_PARITY_EN    = 0;
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: per-bit down-counter; o_tick marks the last cycle of a bit.
// Holds at zero rather than wrapping so idle periods cost nothing.
module uart_baud_cnt import fifo_uart_pkg::*; #(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_load,
   output logic o_tick
);
   localparam int W = $clog2(CLKS_PER_BIT);
   localparam logic [W-1:0] RELOAD = W'(CLKS_PER_BIT - 1);
   logic [W-1:0] r_cnt;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_cnt <= '0;
      else if (i_load) r_cnt <= RELOAD;
      else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   assign o_tick = (r_cnt == '0);
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an upstream FIFO and serialises them as
// UART frames (start, LSB-first data, optional even parity, stop).
module fifo_uart_tx import fifo_uart_pkg::*; #(
   parameter int WIDTH_DATA   = DEF_WIDTH_DATA,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int PARITY_EN    = DEF_PARITY_EN
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [WIDTH_DATA-1:0] i_data,
   input  logic                  i_empty,
   output logic                  o_pop,
   output logic                  o_tx,
   output logic                  o_busy
);
   localparam int BW = $clog2(WIDTH_DATA + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH_DATA - 1);
   state_t                r_state, w_next;
   logic [WIDTH_DATA-1:0] r_shift;
   logic [BW-1:0]         r_bit_cnt;
   logic                  r_par;
   logic                  w_tick, w_load, w_in_bit;
   assign w_in_bit = (r_state == S_START) || (r_state == S_DATA) ||
                     (r_state == S_PARITY) || (r_state == S_STOP);
   // LOAD primes the counter so START gets a full bit period.
   assign w_load = (r_state == S_LOAD) || (w_in_bit && w_tick);
   uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_load (w_load),
      .o_tick (w_tick)
   );
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_state <= S_IDLE;
      else r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (!i_empty) w_next = S_POP;
         S_POP:    w_next = S_LOAD;
         S_LOAD:   w_next = S_START;
         S_START:  if (w_tick) w_next = S_DATA;
         S_DATA:   if (w_tick && r_bit_cnt == LAST_BIT) w_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (w_tick) w_next = S_STOP;
         S_STOP:   if (w_tick) w_next = i_empty ? S_IDLE : S_POP;
         default:  w_next = S_IDLE;
      endcase
   end
   // FIFO data is valid during LOAD, one cycle after the pop strobe.
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_par     <= 1'b0;
      end else if (r_state == S_LOAD) begin
         r_shift   <= i_data;
         r_bit_cnt <= '0;
         r_par     <= ^i_data;
      end else if (r_state == S_DATA && w_tick) begin
         r_shift   <= r_shift >> 1;
         r_bit_cnt <= r_bit_cnt + 1'b1;
      end
   assign o_pop  = (r_state == S_POP);
   assign o_busy = (r_state != S_IDLE);
   assign o_tx   = (r_state == S_START)  ? 1'b0 :
                   (r_state == S_DATA)   ? r_shift[0] :
                   (r_state == S_PARITY) ? r_par : 1'b1;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives two transmitters (no parity / even parity) from
// queue-style FIFO models and checks every line cycle against frame rules.
module tb_fifo_uart_tx;
   localparam int CPB = 4;
   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] tx, busy, pop, emp;
   logic [7:0] dat [2];
   logic [7:0] mem [2][256];
   int         wp [2] = '{0, 0};
   int         rp [2] = '{0, 0};
   int         pops [2] = '{0, 0};
   int         total = 0;
   int         bad = 0;
   always #5 clk = ~clk;
   assign emp[0] = (wp[0] == rp[0]);
   assign emp[1] = (wp[1] == rp[1]);
   fifo_uart_tx #(.WIDTH_DATA(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) u0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(dat[0]), .i_empty(emp[0]),
      .o_pop(pop[0]), .o_tx(tx[0]), .o_busy(busy[0]));
   fifo_uart_tx #(.WIDTH_DATA(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) u1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(dat[1]), .i_empty(emp[1]),
      .o_pop(pop[1]), .o_tx(tx[1]), .o_busy(busy[1]));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // FIFO models: one-cycle read latency after the pop strobe.
   always @(posedge clk)
      for (int k = 0; k < 2; k++)
         if (pop[k] === 1'b1) begin
            chk($sformatf("u%0d_pop_when_empty", k), 32'(emp[k]), 0);
            dat[k]  <= mem[k][8'(rp[k])];
            rp[k]   <= rp[k] + 1;
            pops[k] <= pops[k] + 1;
         end
   task automatic push(input int k, input logic [7:0] b);
      mem[k][8'(wp[k])] = b;
      wp[k]++;
   endtask
   function automatic logic exp_bit(input logic [7:0] b, input int idx, input int pe);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (pe != 0 && idx == 9) return ($countones(b) % 2) == 1;
      return 1'b1;
   endfunction
   task automatic wait_start(input int k);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx[k] === 1'b0) break;
      end
      chk($sformatf("u%0d_start_seen", k), 32'(tx[k]), 0);
   endtask
   // Entered on the negedge that sampled the first START cycle.
   task automatic check_frame(input int k, input logic [7:0] b, input int pe,
                              input int do_push, input logic [7:0] pb);
      int nb;
      nb = 10 + pe;
      for (int idx = 0; idx < nb; idx++)
         for (int c = 0; c < CPB; c++) begin
            if (idx != 0 || c != 0) @(negedge clk);
            if (do_push != 0 && idx == nb - 1 && c == 0) push(k, pb);
            chk($sformatf("u%0d_byte%02h_bit%0d_cyc%0d", k, b, idx, c), 32'(tx[k]), 32'(exp_bit(b, idx, pe)));
            chk($sformatf("u%0d_busy_in_frame", k), 32'(busy[k]), 1);
         end
   endtask
   task automatic gap_then_start(input int k);
      repeat (2) begin
         @(negedge clk);
         chk($sformatf("u%0d_gap_high", k), 32'(tx[k]), 1);
         chk($sformatf("u%0d_gap_busy", k), 32'(busy[k]), 1);
      end
      @(negedge clk);
      chk($sformatf("u%0d_b2b_start", k), 32'(tx[k]), 0);
   endtask
   task automatic check_idle(input int k);
      @(negedge clk);
      chk($sformatf("u%0d_idle_busy", k), 32'(busy[k]), 0);
      chk($sformatf("u%0d_idle_tx", k), 32'(tx[k]), 1);
   endtask
   initial begin
      logic [7:0] rb [4];
      int p;
      repeat (3) @(negedge clk);
      chk("reset_tx", 32'(tx), 2'b11);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_pop", 32'(pop), 0);
      rst_n = 1'b1;
      repeat (100) begin
         @(negedge clk);
         chk("empty_pop", 32'(pop[0]), 0);
         chk("empty_tx", 32'(tx[0]), 1);
         chk("empty_busy", 32'(busy[0]), 0);
      end
      p = pops[0];
      push(0, 8'hA5);
      wait_start(0);
      check_frame(0, 8'hA5, 0, 0, 8'h00);
      check_idle(0);
      chk("a5_pops", 32'(pops[0] - p), 1);
      p = pops[0];
      push(0, 8'h00); push(0, 8'hFF); push(0, 8'h3C);
      wait_start(0);
      check_frame(0, 8'h00, 0, 0, 8'h00);
      gap_then_start(0);
      check_frame(0, 8'hFF, 0, 0, 8'h00);
      gap_then_start(0);
      check_frame(0, 8'h3C, 0, 0, 8'h00);
      check_idle(0);
      chk("three_pops", 32'(pops[0] - p), 3);
      p = pops[0];
      for (int i = 0; i < 4; i++) begin
         rb[i] = 8'($urandom);
         push(0, rb[i]);
      end
      wait_start(0);
      for (int i = 0; i < 4; i++) begin
         if (i != 0) gap_then_start(0);
         check_frame(0, rb[i], 0, 0, 8'h00);
      end
      check_idle(0);
      chk("rand_pops", 32'(pops[0] - p), 4);
      p = pops[1];
      push(1, 8'h07); push(1, 8'h03);
      wait_start(1);
      check_frame(1, 8'h07, 1, 0, 8'h00);
      gap_then_start(1);
      check_frame(1, 8'h03, 1, 0, 8'h00);
      check_idle(1);
      chk("parity_pops", 32'(pops[1] - p), 2);
      // Abort mid-frame in data bit 3 (a zero bit of 0x55), then resume.
      p = pops[0];
      push(0, 8'h55); push(0, 8'h96);
      wait_start(0);
      repeat (4 * CPB + 1) @(negedge clk);
      chk("pre_reset_bit3", 32'(tx[0]), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_tx", 32'(tx[0]), 1);
      chk("async_reset_pop", 32'(pop[0]), 0);
      chk("async_reset_busy", 32'(busy[0]), 0);
      @(negedge clk);
      @(negedge clk);
      chk("held_reset_tx", 32'(tx[0]), 1);
      chk("held_reset_pop", 32'(pop[0]), 0);
      rst_n = 1'b1;
      chk("no_pop_in_reset", 32'(pops[0] - p), 1);
      @(negedge clk);
      chk("first_pop_after_reset", 32'(pop[0]), 1);
      @(negedge clk);
      chk("load_after_reset", 32'(pop[0]), 0);
      @(negedge clk);
      chk("restart_start", 32'(tx[0]), 0);
      check_frame(0, 8'h96, 0, 0, 8'h00);
      check_idle(0);
      chk("reset_pops", 32'(pops[0] - p), 2);
      p = pops[0];
      push(0, 8'hC3);
      wait_start(0);
      check_frame(0, 8'hC3, 0, 1, 8'h5A);
      gap_then_start(0);
      check_frame(0, 8'h5A, 0, 0, 8'h00);
      check_idle(0);
      chk("stop_push_pops", 32'(pops[0] - p), 2);
      chk("stop_push_drained", 32'(emp[0]), 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter WIDTH_DATA, default 8: payload bits per frame, matches the upstream FIFO data width.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16: i_clk cycles per serial bit, legal range 2..65535.
REQ-003 SHALL have parameter PARITY_EN, default 0: 1 inserts one even-parity bit after the data bits.
REQ-004 SHALL have port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_data  input  WIDTH_DATA  upstream FIFO o_data_out.
REQ-007 SHALL have port i_empty  input  1  upstream FIFO o_empty.
REQ-008 SHALL have port o_pop  output  1  pop strobe to upstream FIFO i_pop.
REQ-009 SHALL have port o_tx  output  1  serial line, idle high.
REQ-010 SHALL have port o_busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, POP, LOAD, START, DATA, PARITY, STOP; all outputs registered or decoded from state only.
REQ-012 IDLE -> POP when i_empty=0 is sampled; otherwise stay in IDLE.
REQ-013 POP: o_pop=1 for exactly one cycle; next state LOAD unconditionally.
REQ-014 LOAD: capture i_data into shift register (FIFO read latency = 1 cycle after pop); next state START.
REQ-015 START, DATA, PARITY, STOP: each bit held on o_tx for exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded at every bit boundary.
REQ-016 START drives o_tx=0; DATA drives LSB first, WIDTH_DATA bits; PARITY (only when PARITY_EN=1) drives XOR of captured byte; STOP drives o_tx=1.
REQ-017 At end of STOP: -> POP if i_empty=0, else -> IDLE; back-to-back frames therefore separated by exactly 2 idle-high cycles (POP, LOAD).
REQ-018 o_pop SHALL never assert while i_empty=1 was sampled in the deciding cycle; at most one pop per frame.
REQ-019 Changes on i_data or i_empty outside the LOAD/deciding cycles SHALL NOT affect the frame in flight.
REQ-020 Bit counter width SHALL be $clog2(WIDTH_DATA+1); baud counter width $clog2(CLKS_PER_BIT); no wrap beyond terminal values.
REQ-021 Frame length from first START cycle to last STOP cycle = (WIDTH_DATA+2+PARITY_EN)*CLKS_PER_BIT cycles.

Reset
REQ-022 On i_rst_n=0, immediately: state=IDLE, o_tx=1, o_pop=0, o_busy=0, counters and shift register cleared.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no further pop; the aborted byte is lost.
REQ-024 First possible o_pop SHALL be the second rising edge after i_rst_n deasserts.

Structure
REQ-025 Shared package fifo_uart_pkg SHALL hold the state enum typedef and default parameter constants.
REQ-026 Baud timing SHALL be one sub-module uart_baud_cnt (load, tick-at-terminal output); FSM and shift register stay in fifo_uart_tx.

Verification (WIDTH_DATA=8, CLKS_PER_BIT=4 unless noted)
REQ-027 Reset then i_empty held 1 for 100 cycles -> o_pop never asserts, o_tx=1, o_busy=0.
REQ-028 FIFO preloaded with 0xA5, i_empty falls -> one o_pop, o_tx sequence 0,1,0,1,0,0,1,0,1,1 each 4 cycles, 40-cycle frame, then IDLE.
REQ-029 FIFO preloaded with 0x00,0xFF,0x3C -> three pops, each frame 40 cycles, 2 idle-high cycles between frames, bytes decoded in order.
REQ-030 PARITY_EN=1, byte 0x07 -> parity bit 1, frame 44 cycles; byte 0x03 -> parity bit 0.
REQ-031 i_rst_n pulsed low in DATA bit 3 -> o_tx=1 same cycle asynchronously, o_pop=0, after release next frame starts from START with the next FIFO byte.
REQ-032 Push to FIFO during STOP of last frame -> pop issued on the cycle after STOP ends, no loss or duplication.
